// File: rtl/cpu_mem_pkg.sv
// Shared types and default sizes for the CPU memory-port arbiter.
// The arbiter states and the owner encoding are defined here.
package cpu_mem_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_watchdog.sv
// Wait-cycle counter for the memory handshake.
// Asserts expired in the TIMEOUT-th enabled cycle that follows a clear.
module mem_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The current cycle is the TIMEOUT-th wait cycle when TIMEOUT-1 cycles have already been counted.
    assign expired_o = enable_i && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one variable-latency memory.
// Data requests take priority over fetch requests. A watchdog forces completion when the memory does not acknowledge.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic              m_we_q, m_we_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              in_wait;
    logic              expired;
    logic [DATA_W-1:0] resp_data;

    assign in_wait = (state_q == I_WAIT) || (state_q == D_WAIT);

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (!in_wait),
        .enable_i  (in_wait),
        .expired_o (expired)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        m_addr_d  = m_addr_q;
        m_we_d    = m_we_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;
        resp_data = '0;

        unique case (state_q)
            IDLE: begin
                if (d_req) begin
                    m_addr_d  = d_addr;
                    m_we_d    = d_we;
                    m_wdata_d = d_wdata;
                    owner_d   = OWNER_D;
                    state_d   = D_WAIT;
                end else if (i_req) begin
                    m_addr_d = i_addr;
                    m_we_d   = 1'b0;
                    owner_d  = OWNER_I;
                    state_d  = I_WAIT;
                end
            end
            I_WAIT, D_WAIT: begin
                // An acknowledge in the expiry cycle still counts as a normal completion.
                if (m_ack || expired) begin
                    resp_data = (m_ack && !m_we_q) ? m_rdata : '0;
                    err_d     = !m_ack;
                    state_d   = RESP;
                    if (state_q == I_WAIT) begin
                        i_rdata_d = resp_data;
                    end else begin
                        d_rdata_d = resp_data;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= OWNER_I;
            m_addr_q  <= '0;
            m_we_q    <= 1'b0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            m_addr_q  <= m_addr_d;
            m_we_q    <= m_we_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    assign m_req     = in_wait;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = (state_q == RESP) && (owner_q == OWNER_I);
    assign d_ready   = (state_q == RESP) && (owner_q == OWNER_D);
    assign err       = (state_q == RESP) && err_q;
    assign busy      = (state_q != IDLE);
    assign stall_if  = i_req & ~i_ready;
    assign stall_mem = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with TIMEOUT=4.
// Inputs are driven on the falling edge, and outputs are checked 1 ns later.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ready, d_ready, m_req, m_we, stall_if, stall_mem, err, busy;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        step(); step();
        reset = 1'b0; #1;
        check1 ("rst_busy",    busy,    1'b0);
        check1 ("rst_m_req",   m_req,   1'b0);
        check1 ("rst_m_we",    m_we,    1'b0);
        check32("rst_m_addr",  m_addr,  32'h0);
        check32("rst_i_rdata", i_rdata, 32'h0);
        check1 ("rst_err",     err,     1'b0);

        // An acknowledge while idle is ignored.
        step(); m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF; #1;
        step(); m_ack = 1'b0; #1;
        check1 ("idle_ack_busy",  busy,    1'b0);
        check1 ("idle_ack_dready", d_ready, 1'b0);
        check32("idle_ack_drdata", d_rdata, 32'h0);

        // Fetch only: the memory acknowledges in the fourth m_req cycle.
        step(); i_req = 1'b1; i_addr = 32'h40; #1;
        check1("f_stall_req", stall_if, 1'b1);
        check1("f_mreq_idle", m_req,    1'b0);
        step(); #1;
        check1 ("f_mreq_c1",  m_req,    1'b1);
        check32("f_maddr",    m_addr,   32'h40);
        check1 ("f_mwe",      m_we,     1'b0);
        check1 ("f_stall_c1", stall_if, 1'b1);
        step(); #1; check1("f_mreq_c2", m_req, 1'b1);
        step(); #1; check1("f_mreq_c3", m_req, 1'b1);
        step(); m_ack = 1'b1; m_rdata = 32'h00A0_0093; #1;
        check1("f_ready_c4", i_ready, 1'b0);
        step(); m_ack = 1'b0; #1;
        check1 ("f_ready",      i_ready,  1'b1);
        check32("f_rdata",      i_rdata,  32'h00A0_0093);
        check1 ("f_stall_done", stall_if, 1'b0);
        check1 ("f_mreq_resp",  m_req,    1'b0);
        check1 ("f_err",        err,      1'b0);
        check1 ("f_busy_resp",  busy,     1'b1);
        step(); i_req = 1'b0; #1;
        check1("f_ready_once", i_ready, 1'b0);
        check1("f_busy_idle",  busy,    1'b0);
        step(); #1;
        check1("f_no_regrant", m_req, 1'b0);

        // Conflict: data beats fetch. The load is acknowledged in its first cycle.
        step(); i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; #1;
        step(); m_ack = 1'b1; m_rdata = 32'h1122_3344; #1;
        check32("c_maddr_data", m_addr,    32'h100);
        check1 ("c_mwe",        m_we,      1'b0);
        check1 ("c_stall_if",   stall_if,  1'b1);
        check1 ("c_stall_mem",  stall_mem, 1'b1);
        step(); m_ack = 1'b0; #1;
        check1 ("c_dready",     d_ready,   1'b1);
        check1 ("c_iready",     i_ready,   1'b0);
        check32("c_drdata",     d_rdata,   32'h1122_3344);
        check1 ("c_stall_mem0", stall_mem, 1'b0);
        check1 ("c_stall_if1",  stall_if,  1'b1);
        step(); d_req = 1'b0; #1;
        check1("c_idle_gap", m_req, 1'b0);
        check1("c_idle_busy", busy, 1'b0);
        step(); #1;
        check1 ("c_fetch_mreq",  m_req,  1'b1);
        check32("c_fetch_maddr", m_addr, 32'h44);
        m_ack = 1'b1; m_rdata = 32'h0000_0055;
        step(); m_ack = 1'b0; #1;
        check1 ("c_fetch_ready", i_ready, 1'b1);
        check32("c_fetch_rdata", i_rdata, 32'h55);
        check32("c_drdata_keep", d_rdata, 32'h1122_3344);
        step(); i_req = 1'b0; #1;

        // Store acknowledged in its first cycle, so its read data reads back as zero.
        step(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; #1;
        step(); m_ack = 1'b1; m_rdata = 32'h1234_5678; #1;
        check1 ("s_mwe",    m_we,    1'b1);
        check32("s_mwdata", m_wdata, 32'hDEAD_BEEF);
        check32("s_maddr",  m_addr,  32'h200);
        step(); m_ack = 1'b0; #1;
        check1 ("s_dready", d_ready, 1'b1);
        check32("s_drdata", d_rdata, 32'h0);
        step(); d_req = 1'b0; d_we = 1'b0; #1;

        // Timeout: m_req stays high for 4 cycles, then the response carries err=1.
        step(); d_req = 1'b1; d_addr = 32'h300; d_wdata = 32'h5555_5555; #1;
        step(); #1; check1("t_mreq_c1", m_req, 1'b1);
        step(); #1; check1("t_mreq_c2", m_req, 1'b1);
        step(); #1; check1("t_mreq_c3", m_req, 1'b1);
        step(); #1; check1("t_mreq_c4", m_req, 1'b1);
        check1("t_no_ready_c4", d_ready, 1'b0);
        step(); m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0; #1;
        check1 ("t_dready", d_ready, 1'b1);
        check1 ("t_err",    err,     1'b1);
        check32("t_drdata", d_rdata, 32'h0);
        check1 ("t_mreq0",  m_req,   1'b0);
        step(); m_ack = 1'b0; d_req = 1'b0; #1;
        check1 ("t_err_clr",    err,     1'b0);
        check1 ("t_late_ack",   d_ready, 1'b0);
        check32("t_late_rdata", d_rdata, 32'h0);
        check1 ("t_late_busy",  busy,    1'b0);

        // An acknowledge in the expiry cycle wins over the timeout.
        step(); i_req = 1'b1; i_addr = 32'h48; #1;
        step(); step(); step();
        step(); m_ack = 1'b1; m_rdata = 32'h0000_CAFE; #1;
        step(); m_ack = 1'b0; #1;
        check1 ("b_iready", i_ready, 1'b1);
        check1 ("b_err",    err,     1'b0);
        check32("b_irdata", i_rdata, 32'hCAFE);
        step(); i_req = 1'b0; #1;

        // Reset asserted in the middle of D_WAIT.
        step(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h5555_5555; #1;
        step(); #1; check1("r_mreq_pre", m_req, 1'b1);
        reset = 1'b1;
        step(); reset = 1'b0; d_req = 1'b0; #1;
        check1 ("r_mreq",    m_req,   1'b0);
        check1 ("r_busy",    busy,    1'b0);
        check1 ("r_dready",  d_ready, 1'b0);
        check32("r_maddr",   m_addr,  32'h0);
        check32("r_mwdata",  m_wdata, 32'h0);
        check32("r_irdata",  i_rdata, 32'h0);
        check1 ("r_err",     err,     1'b0);
        step(); #1; check1("r_dready_later", d_ready, 1'b0);
        step(); i_req = 1'b1; i_addr = 32'h80; #1;
        step(); #1;
        check32("r_fetch_maddr", m_addr, 32'h80);
        m_ack = 1'b1; m_rdata = 32'h0000_0077;
        step(); m_ack = 1'b0; #1;
        check1 ("r_fetch_ready", i_ready, 1'b1);
        check32("r_fetch_rdata", i_rdata, 32'h77);
        step(); i_req = 1'b0; #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
